// File: rtl/memctrl_cmd_seq.sv
// Command sequencer for MEMCTRL: turns one valid/ready read or write command into
// the CE/CSB/WEB/OEB strobe waveform and returns a one-cycle completion response.
module memctrl_cmd_seq #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CE_HALF = 3
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              hold,
    output logic              rsp_valid,
    output logic              rsp_is_rd,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [15:0]       done_cnt,
    output logic              CE,
    output logic              CSB,
    output logic              WEB,
    output logic              OEB,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] IDATA,
    input  logic [DATA_W-1:0] ODATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_CE_H1,
        S_CE_L1,
        S_CE_H2,
        S_CE_L2
    } state_t;

    // cnt_q holds the remaining cycles in the current phase minus one
    localparam logic [3:0] HALF_M1 = 4'(CE_HALF - 1);
    localparam logic [3:0] H1_M1   = 4'(CE_HALF - 2);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                ce_q, ce_d;
    logic                csb_q, csb_d;
    logic                web_q, web_d;
    logic                oeb_q, oeb_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   idata_q, idata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_is_rd_q, rsp_is_rd_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [15:0]         done_cnt_q, done_cnt_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        ce_d        = ce_q;
        csb_d       = csb_q;
        web_d       = web_q;
        oeb_d       = oeb_q;
        addr_d      = addr_q;
        idata_d     = idata_q;
        rsp_valid_d = 1'b0;
        rsp_is_rd_d = rsp_is_rd_q;
        rsp_rdata_d = rsp_rdata_q;
        done_cnt_d  = done_cnt_q;
        cmd_ready   = (state_q == S_IDLE) && !hold;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_d = S_ASSERT;
                    cnt_d   = '0;
                    we_d    = cmd_we;
                    addr_d  = cmd_addr;
                    if (cmd_we) begin
                        idata_d = cmd_wdata;
                    end
                    ce_d  = 1'b1;
                    csb_d = 1'b0;
                    web_d = !cmd_we;
                    oeb_d = cmd_we;
                end
            end
            S_ASSERT: begin
                state_d = S_CE_H1;
                cnt_d   = H1_M1;
                csb_d   = 1'b1;
                web_d   = 1'b1;
            end
            S_CE_H1: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_CE_L1;
                    cnt_d   = HALF_M1;
                    ce_d    = 1'b0;
                end
            end
            S_CE_L1: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // ODATA is still driven here because OEB only rises on this edge
                    state_d     = S_CE_H2;
                    cnt_d       = HALF_M1;
                    ce_d        = 1'b1;
                    oeb_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_is_rd_d = !we_q;
                    rsp_rdata_d = we_q ? '0 : ODATA;
                    done_cnt_d  = done_cnt_q + 16'd1;
                end
            end
            S_CE_H2: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_CE_L2;
                    cnt_d   = HALF_M1;
                    ce_d    = 1'b0;
                end
            end
            S_CE_L2: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            ce_q        <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            oeb_q       <= 1'b1;
            addr_q      <= '0;
            idata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_is_rd_q <= 1'b0;
            rsp_rdata_q <= '0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            ce_q        <= ce_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            oeb_q       <= oeb_d;
            addr_q      <= addr_d;
            idata_q     <= idata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_is_rd_q <= rsp_is_rd_d;
            rsp_rdata_q <= rsp_rdata_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign CE        = ce_q;
    assign CSB       = csb_q;
    assign WEB       = web_q;
    assign OEB       = oeb_q;
    assign ADDR      = addr_q;
    assign IDATA     = idata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_is_rd = rsp_is_rd_q;
    assign rsp_rdata = rsp_rdata_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_memctrl_cmd_seq.sv
// Bench for memctrl_cmd_seq: phase-based waveform model, response scoreboard and
// a pin-level memory that serves ODATA from what the strobes actually wrote.
module tb_memctrl_cmd_seq;

    localparam int CH = 3;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        hold;
    logic        rsp_valid;
    logic        rsp_is_rd;
    logic [7:0]  rsp_rdata;
    logic [15:0] done_cnt;
    logic        CE, CSB, WEB, OEB;
    logic [15:0] ADDR;
    logic [7:0]  IDATA;
    logic [7:0]  ODATA;

    memctrl_cmd_seq #(.ADDR_W(16), .DATA_W(8), .CE_HALF(CH)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .hold(hold),
        .rsp_valid(rsp_valid), .rsp_is_rd(rsp_is_rd), .rsp_rdata(rsp_rdata),
        .done_cnt(done_cnt),
        .CE(CE), .CSB(CSB), .WEB(WEB), .OEB(OEB),
        .ADDR(ADDR), .IDATA(IDATA), .ODATA(ODATA)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] mem_init(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    // pin-level memory: written by the strobes, read back through ODATA
    logic [7:0] env_mem [0:65535];
    initial begin
        for (int i = 0; i < 65536; i++) env_mem[i] = mem_init(16'(i));
        env_mem[16'h00FF] = 8'h5A;
    end
    always @(negedge CLK) begin
        if (RSTN && !CSB && !WEB) env_mem[ADDR] = IDATA;
    end
    assign ODATA = OEB ? 8'hEE : env_mem[ADDR];

    // reference model
    typedef struct {
        int         due;
        logic       is_rd;
        logic [7:0] rdata;
    } rsp_t;

    rsp_t        sb[$];
    logic [7:0]  model_mem [0:65535];
    int          total = 0;
    int          bad = 0;
    int          n = 0;
    int          acc_n = -1000;
    int unsigned acc_count = 0;
    logic        acc_we;
    logic [15:0] acc_addr;
    logic [7:0]  acc_wdata;
    logic [7:0]  acc_rdata;
    logic [15:0] exp_addr = '0;
    logic [7:0]  exp_idata = '0;
    logic [15:0] done_exp = '0;
    logic        last_rd = 1'b0;
    logic [7:0]  last_rdata = '0;

    initial begin
        for (int i = 0; i < 65536; i++) model_mem[i] = mem_init(16'(i));
        model_mem[16'h00FF] = 8'h5A;
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, n, act, exp);
        end
    endfunction

    always @(negedge CLK) begin
        int   p;
        logic busy, e_ce, e_csb, e_web, e_oeb, e_rdy;
        rsp_t it;
        n++;
        if (!RSTN) begin
            chk("rst_CE", CE, 0);
            chk("rst_CSB", CSB, 1);
            chk("rst_WEB", WEB, 1);
            chk("rst_OEB", OEB, 1);
            chk("rst_ADDR", ADDR, 0);
            chk("rst_IDATA", IDATA, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_is_rd", rsp_is_rd, 0);
            chk("rst_rsp_rdata", rsp_rdata, 0);
            chk("rst_done_cnt", done_cnt, 0);
            acc_n      = -1000;
            sb.delete();
            done_exp   = '0;
            exp_addr   = '0;
            exp_idata  = '0;
            last_rd    = 1'b0;
            last_rdata = '0;
        end else begin
            p    = n - acc_n;
            busy = (p >= 1) && (p <= 4 * CH);
            if (p == 1) begin
                exp_addr = acc_addr;
                if (acc_we) exp_idata = acc_wdata;
            end
            if (p == 2 * CH + 1) begin
                done_exp   = done_exp + 16'd1;
                last_rd    = !acc_we;
                last_rdata = acc_rdata;
            end
            e_ce  = busy && ((p <= CH) || (p > 2 * CH && p <= 3 * CH));
            e_csb = !(busy && p == 1);
            e_web = !(busy && p == 1 && acc_we);
            e_oeb = !(busy && !acc_we && p <= 2 * CH);
            e_rdy = !busy && !hold;
            chk("CE", CE, e_ce);
            chk("CSB", CSB, e_csb);
            chk("WEB", WEB, e_web);
            chk("OEB", OEB, e_oeb);
            chk("ADDR", ADDR, exp_addr);
            chk("IDATA", IDATA, exp_idata);
            chk("cmd_ready", cmd_ready, e_rdy);
            chk("done_cnt", done_cnt, done_exp);
            chk("rsp_is_rd_hold", rsp_is_rd, last_rd);
            chk("rsp_rdata_hold", rsp_rdata, last_rdata);

            if (sb.size() > 0 && sb[0].due < n) begin
                it = sb.pop_front();
                total++;
                bad++;
                $display("FAIL rsp_missing cyc=%0d got=none exp=pulse@%0d", n, it.due);
            end
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_spurious cyc=%0d got=pulse exp=none", n);
                end else begin
                    it = sb.pop_front();
                    chk("rsp_cycle", n, it.due);
                    chk("rsp_is_rd", rsp_is_rd, it.is_rd);
                    chk("rsp_rdata", rsp_rdata, it.rdata);
                end
            end

            if (cmd_valid && e_rdy) begin
                acc_n     = n;
                acc_we    = cmd_we;
                acc_addr  = cmd_addr;
                acc_wdata = cmd_wdata;
                if (cmd_we) begin
                    model_mem[cmd_addr] = cmd_wdata;
                    acc_rdata = '0;
                end else begin
                    acc_rdata = model_mem[cmd_addr];
                end
                it.due   = n + 2 * CH + 1;
                it.is_rd = !cmd_we;
                it.rdata = acc_rdata;
                sb.push_back(it);
                acc_count++;
            end
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic we, input logic [15:0] a, input logic [7:0] d);
        int unsigned start;
        start     = acc_count;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        for (int i = 0; i < 300; i++) begin
            @(posedge CLK);
            #1;
            if (acc_count != start) return;
        end
        $display("FAIL issue_timeout cyc=%0d got=no_accept exp=accept", n);
        $fatal(1);
    endtask

    initial begin
        RSTN      = 1'b0;
        hold      = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        repeat (2) @(posedge CLK);
        #2 RSTN = 1'b1;
        cycles(2);

        issue(1'b1, 16'h1234, 8'hA5);
        cmd_valid = 1'b0;
        cycles(14);

        issue(1'b0, 16'h00FF, 8'h00);
        cmd_valid = 1'b0;
        cycles(14);

        issue(1'b1, 16'h0040, 8'h3C);
        issue(1'b0, 16'h0040, 8'hFF);
        issue(1'b1, 16'h0041, 8'h77);
        cmd_valid = 1'b0;
        cycles(14);

        issue(1'b1, 16'h0100, 8'hC3);
        cmd_valid = 1'b0;
        cycles(4);
        hold      = 1'b1;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 16'h0100;
        cycles(15);
        hold = 1'b0;
        issue(1'b0, 16'h0100, 8'h00);
        cmd_valid = 1'b0;
        cycles(14);

        issue(1'b0, 16'h0100, 8'h00);
        cmd_valid = 1'b0;
        repeat (4) @(posedge CLK);
        #2 RSTN = 1'b0;
        @(posedge CLK);
        #2 RSTN = 1'b1;
        cycles(14);
        issue(1'b1, 16'h0200, 8'h99);
        cmd_valid = 1'b0;
        cycles(14);
        issue(1'b0, 16'h0200, 8'h00);
        cmd_valid = 1'b0;
        cycles(3);

        for (int t = 0; t < 60; t++) begin
            logic [15:0] a;
            a = 16'h0300 + 16'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                hold      = 1'b1;
                cmd_valid = 1'($urandom);
                cmd_addr  = 16'($urandom);
                cycles(int'($urandom_range(1, 20)));
                hold = 1'b0;
            end
            issue(1'($urandom), a, 8'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                cmd_valid = 1'b0;
                cmd_addr  = 16'($urandom);
                cycles(int'($urandom_range(0, 3)));
            end
        end
        cmd_valid = 1'b0;
        cycles(4 * CH + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
